// File: rtl/clock_scale_meter.sv
// -----------------------------------------------------------------------------
// clock_scale_meter
//
// Measures the half-period of a slow free-running square wave (clk_in) in CCLK
// cycles and reports it as the clk_scale value a CCLK-based divider would need
// to reproduce that wave. Also reports the individual high/low phase lengths,
// the full period, a lock indication and a stall indication.
//
// Ports:
//   CCLK         in   100 MHz system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   clk_in       in   clock under measurement, asynchronous to CCLK
//   clear        in   synchronous restart of the measurement (level)
//   scale_out    out  most recent half-period in CCLK cycles
//   high_len     out  most recent high-phase length
//   low_len      out  most recent low-phase length
//   period       out  high_len + low_len, full width (CNT_W+1 bits)
//   sample_valid out  one-cycle pulse when scale_out is updated
//   locked       out  consecutive half-periods agree within TOL
//   stalled      out  no clk_in edge seen for TIMEOUT cycles
//   state_dbg    out  current measurement state (0 WAIT, 1 MEASURE, 2 STALLED)
//
// There is no valid/ready handshake: sample_valid is a pure strobe, the data
// outputs are registered and hold their value between strobes.
// -----------------------------------------------------------------------------
module clock_scale_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100_000_000,
    parameter int unsigned TOL         = 0
) (
    input  logic             CCLK,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clear,
    output logic [CNT_W-1:0] scale_out,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             sample_valid,
    output logic             locked,
    output logic             stalled,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_MEASURE = 2'd1,
        S_STALLED = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_s;
    logic                   edge_det;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_s ^ prev_q;
    assign rise     = edge_det & sync_s;
    assign fall     = edge_det & ~sync_s;

    // ------------------------------------------------------------------
    // Interval counter: loads 1 on an edge so that two edges N cycles
    // apart leave cnt_q == N during the second edge's cycle.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic             hit_timeout;

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (edge_det) begin
            cnt_q <= ONE_V;
        end else if (cnt_q != TIMEOUT_V) begin
            cnt_q <= cnt_q + ONE_V;
        end
    end

    assign hit_timeout = (cnt_q == TIMEOUT_V);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. An edge always beats the timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT:    if (edge_det) state_d = S_MEASURE;
                S_MEASURE: if (!edge_det && hit_timeout) state_d = S_STALLED;
                S_STALLED: if (edge_det) state_d = S_MEASURE;
                default:   state_d = S_WAIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Edges seen in WAIT or STALLED only re-arm the
    // measurement; the interval behind them is partial.
    // ------------------------------------------------------------------
    logic capture;
    logic enter_stall;

    always_comb begin
        capture     = 1'b0;
        enter_stall = 1'b0;
        stalled     = 1'b0;
        state_dbg   = state_q;
        if (state_q == S_MEASURE && edge_det && !clear) begin
            capture = 1'b1;
        end
        if (state_q == S_MEASURE && state_d == S_STALLED) begin
            enter_stall = 1'b1;
        end
        if (state_q == S_STALLED) begin
            stalled = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture datapath
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] prev_half;
    logic             have_high;
    logic             have_low;
    logic             have_ref;
    logic [CNT_W-1:0] half_diff;
    logic [CNT_W-1:0] high_next;
    logic [CNT_W-1:0] low_next;
    logic [CNT_W:0]   period_next;
    logic             both_next;

    assign half_diff   = (cnt_q >= prev_half) ? (cnt_q - prev_half) : (prev_half - cnt_q);
    // Period uses the phase being captured this cycle plus the stored other one.
    assign high_next   = fall ? cnt_q : high_len;
    assign low_next    = rise ? cnt_q : low_len;
    assign period_next = {1'b0, high_next} + {1'b0, low_next};
    assign both_next   = (have_high | fall) & (have_low | rise);

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            scale_out    <= '0;
            high_len     <= '0;
            low_len      <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            prev_half    <= '0;
            have_high    <= 1'b0;
            have_low     <= 1'b0;
            have_ref     <= 1'b0;
        end else if (clear) begin
            scale_out    <= '0;
            high_len     <= '0;
            low_len      <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            prev_half    <= '0;
            have_high    <= 1'b0;
            have_low     <= 1'b0;
            have_ref     <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                scale_out <= cnt_q;
                prev_half <= cnt_q;
                have_ref  <= 1'b1;
                // First capture after re-arming has no reference to compare.
                locked    <= have_ref && (half_diff <= TOL_V);
                if (fall) begin
                    high_len  <= cnt_q;
                    have_high <= 1'b1;
                end else begin
                    low_len  <= cnt_q;
                    have_low <= 1'b1;
                end
                if (both_next) begin
                    period <= period_next;
                end
            end else if (enter_stall) begin
                // Data outputs hold; only the lock and the phase history drop.
                locked    <= 1'b0;
                have_high <= 1'b0;
                have_low  <= 1'b0;
                have_ref  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/clock_scale_meter.md
# clock_scale_meter

Measures the half-period of a slow, free-running square-wave clock in CCLK cycles and reports it as the clk_scale value that a divider running from the 100 MHz CCLK would need to reproduce that clock. It sits beside the board's clock divider and the Sequence_Detector logic. It is used to check and calibrate divided clocks on the Basys3: it measures what the divider generates, where the divider generates what it is told. It also reports per-phase lengths, full period, lock, and stall status.

## Interface
- CNT_W, 32, width of all length counters and outputs.
- SYNC_STAGES, 2, flip-flops in the clk_in synchronizer (legal values ≥ 2).
- TIMEOUT, 100_000_000, CCLK cycles without an edge before the input is declared stalled (1 s).
- TOL, 0, maximum absolute difference between consecutive half-periods for lock.

- CCLK  in  1  100 MHz crystal clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_in  in  1  clock under measurement; asynchronous to CCLK.
- clear  in  1  synchronous restart of the measurement; level-sensitive.
- scale_out  out  CNT_W  most recent half-period in CCLK cycles, i.e. the equivalent clk_scale.
- high_len  out  CNT_W  most recent high-phase length.
- low_len  out  CNT_W  most recent low-phase length.
- period  out  CNT_W+1  high_len + low_len; valid once both phases are captured.
- sample_valid  out  1  one-cycle pulse when scale_out is updated.
- locked  out  1  consecutive half-periods agree within TOL.
- stalled  out  1  no clk_in edge seen for TIMEOUT cycles.

## Operation
- **Synchronizer and edge detection**
  - clk_in passes through a SYNC_STAGES flop chain, then through one more flop (prev).
  - edge = sync XOR prev. rise = edge & sync; fall = edge & ~sync.
- **Counter (cnt)**
  - Loads 1 on any edge.
  - Otherwise increments, saturating at TIMEOUT.
  - Two edges N cycles apart give cnt = N at the second edge.
- **State machine**
  - WAIT: entered on reset or clear. First edge → MEASURE; no capture, because the interval is partial.
  - MEASURE, on edge: capture half = cnt.
    - fall → high_len ← half; rise → low_len ← half.
    - scale_out ← half; sample_valid = 1.
  - MEASURE, no edge and cnt == TIMEOUT → STALLED.
  - STALLED: stalled = 1, locked = 0, data outputs hold. The next edge → MEASURE with no capture, and stalled clears.
- **Lock**
  - On each capture, compare half against the previous capture (prev_half) using the absolute difference.
  - diff ≤ TOL → locked = 1; else locked = 0.
  - The first capture after WAIT or STALLED has no reference and leaves locked = 0.
- **Period**
  - period = high_len + low_len, registered, computed at full width with no overflow.
  - Updated on each capture once both high_len and low_len have been captured since WAIT or STALLED.
  - Before that, period holds its previous value.
- **clear**
  - Highest priority after reset.
  - → WAIT; zeroes scale_out, high_len, low_len, period; locked = stalled = 0.
  - An edge in the same cycle as clear is discarded.
- **Simultaneous events**
  - An edge in the same cycle that cnt reaches TIMEOUT is captured normally; the edge beats stall.
- **Reset values**
  - All outputs 0; sync chain, prev, cnt and prev_half 0; state WAIT.
  - If clk_in is high at reset release, the resulting synchronized rise is a valid first edge in WAIT.

## Timing
- A clk_in transition meeting setup before CCLK edge k:
  - appears at the sync output after edge k+SYNC_STAGES−1;
  - raises edge in the following cycle;
  - updates outputs and pulses sample_valid at edge k+SYNC_STAGES. Total latency is SYNC_STAGES+1 CCLK edges.
- Measurement uncertainty is ±1 CCLK cycle per half-period when clk_in is asynchronous. A clk_in derived from CCLK measures exactly.
- stalled asserts TIMEOUT cycles after the last edge pulse. There is no sample_valid on entry to STALLED.
- sample_valid is never asserted on two consecutive cycles unless clk_in toggles at or above CCLK/2; such inputs are out of specification.
- Minimum measurable half-period: 2 CCLK cycles.

## Test plan
- **Divider equivalence.** clk_in toggles every 4 CCLK cycles, synchronous to CCLK. → From the 2nd edge: scale_out = high_len = low_len = 4. period = 8 once both phases are captured. locked = 1 from the 2nd capture; sample_valid every 4 cycles.
- **Asymmetric duty.** High 3 cycles, low 7 cycles, TOL = 0. → high_len = 3, low_len = 7, period = 10, scale_out alternates 3/7, locked stays 0. With TOL = 4, locked = 1.
- **Stall and recovery.** TIMEOUT = 50. Toggle every 5 cycles, then hold clk_in. → stalled = 1 exactly 50 cycles after the last edge pulse; locked = 0; outputs hold. Resume toggling → first edge clears stalled with no capture; the next edge captures 5.
- **Edge at timeout.** TIMEOUT = 20, edges exactly 20 cycles apart. → Captures 20 every time; stalled never asserts.
- **Clear mid-operation.** Assert clear coincident with an edge while locked = 1. → Next cycle all data outputs are 0, locked = 0, no sample_valid. The first capture comes on the 2nd edge after clear.
- **Async reset.** Pulse rst_n low mid-phase and between CCLK edges. → All outputs 0 immediately. After release, behaviour is as after power-up, including the clk_in-high-at-release first edge.
